// File: rtl/scipio_alu_pkg.sv
// ============================================================================
// Module : scipio_alu_pkg
// Brief  : ALU opcode encoding and age-matrix helper shared by the ALU RS/core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scipio_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDU = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_NOR  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_ROR  = 4'd11,
        OP_SEQ  = 4'd12,
        OP_SLT  = 4'd13,
        OP_SLTU = 4'd14
    } alu_op_e;

    // New entry in `slot` is younger than every other entry that currently holds an instruction.
    function automatic logic age_older(input logic other_valid, input int other, input int slot);
        return other_valid && (other != slot);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module : alu_exec
// Brief  : Purely combinational ALU, DATA_W wide; undefined opcodes yield 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec
    import scipio_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]   w_sh;
    logic [DATA_W-1:0] w_ror;

    assign w_sh  = src2_i[SH_W-1:0];
    // A zero rotate shifts the left half out entirely, leaving src1 unchanged.
    assign w_ror = (src1_i >> w_sh) | (src1_i << (DATA_W - int'(w_sh)));

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD, OP_ADDU: result_o = src1_i + src2_i;
            OP_SUB, OP_SUBU: result_o = src1_i - src2_i;
            OP_AND:          result_o = src1_i & src2_i;
            OP_OR:           result_o = src1_i | src2_i;
            OP_NOR:          result_o = ~(src1_i | src2_i);
            OP_XOR:          result_o = src1_i ^ src2_i;
            OP_SLL:          result_o = src1_i << w_sh;
            OP_SRL:          result_o = src1_i >> w_sh;
            OP_SRA:          result_o = $unsigned($signed(src1_i) >>> w_sh);
            OP_ROR:          result_o = w_ror;
            OP_SEQ:          result_o = {{(DATA_W-1){1'b0}}, src1_i == src2_i};
            OP_SLT:          result_o = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            OP_SLTU:         result_o = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
            default:         result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs_pipe.sv
// ============================================================================
// Module : alu_rs_pipe
// Brief  : ALU reservation station with CDB wakeup, oldest-first issue and a
//          registered single-cycle execute result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs_pipe
    import scipio_alu_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int TAG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int CDB_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [TAG_W-1:0]                     in_target_i,
    input  logic [3:0]                           in_op_i,
    input  logic [DATA_W-1:0]                    in_val1_i,
    input  logic [DATA_W-1:0]                    in_val2_i,
    input  logic [TAG_W-1:0]                     in_tag1_i,
    input  logic [TAG_W-1:0]                     in_tag2_i,
    input  logic                                 in_rdy1_i,
    input  logic                                 in_rdy2_i,
    input  logic [CDB_PORTS-1:0]                 cdb_valid_i,
    input  logic [CDB_PORTS-1:0][TAG_W-1:0]      cdb_tag_i,
    input  logic [CDB_PORTS-1:0][DATA_W-1:0]     cdb_val_i,
    output logic                                 out_valid_o,
    output logic [TAG_W-1:0]                     out_target_o,
    output logic [DATA_W-1:0]                    out_result_o,
    output logic [$clog2(ENTRIES+1)-1:0]         count_o
);

    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       target;
        logic [3:0]             op;
        logic [1:0][DATA_W-1:0] val;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0]             rdy;
    } rs_entry_t;

    rs_entry_t ent_q [ENTRIES];
    rs_entry_t ent_d [ENTRIES];

    // older_q[j][i] set means entry j was inserted before entry i.
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;

    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_target_q, out_target_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;

    logic [ENTRIES-1:0] w_valid, w_ready, w_free, w_grant;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_issue, w_accept;
    logic [CNT_W-1:0]   w_count;
    logic [DATA_W-1:0]  w_alu_result;

    // Returns {hit, value}; the lowest matching port wins.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]                 tag,
        input logic [CDB_PORTS-1:0]             cv,
        input logic [CDB_PORTS-1:0][TAG_W-1:0]  ct,
        input logic [CDB_PORTS-1:0][DATA_W-1:0] cd
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cv[p] && (ct[p] == tag)) r = {1'b1, cd[p]};
        end
        return r;
    endfunction

    always_comb begin : p_status
        logic found;
        found   = 1'b0;
        w_free  = '0;
        w_count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_valid[i] = ent_q[i].valid;
            w_ready[i] = ent_q[i].valid && (&ent_q[i].rdy);
            w_count    = w_count + CNT_W'(ent_q[i].valid);
            if (!ent_q[i].valid && !found) begin
                w_free[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign in_ready_o = ~(&w_valid);
    assign count_o    = w_count;
    assign w_accept   = in_valid_i && in_ready_o;

    // Oldest ready entry: no other ready entry is older than it.
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_grant[i] = w_ready[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (w_ready[j] && older_q[j][i]) w_grant[i] = 1'b0;
            end
            if (w_grant[i]) w_sel_idx = IDX_W'(i);
        end
    end

    assign w_issue = |w_grant;

    alu_exec #(
        .DATA_W (DATA_W)
    ) u_alu_exec (
        .op_i     (ent_q[w_sel_idx].op),
        .src1_i   (ent_q[w_sel_idx].val[0]),
        .src2_i   (ent_q[w_sel_idx].val[1]),
        .result_o (w_alu_result)
    );

    always_comb begin
        logic [DATA_W:0] snp;
        snp          = '0;
        ent_d        = ent_q;
        older_d      = older_q;
        out_valid_d  = 1'b0;
        out_target_d = out_target_q;
        out_result_d = out_result_q;
        if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) ent_d[i].valid = 1'b0;
            older_d = '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int k = 0; k < 2; k++) begin
                    snp = snoop(ent_q[i].tag[k], cdb_valid_i, cdb_tag_i, cdb_val_i);
                    if (ent_q[i].valid && !ent_q[i].rdy[k] && snp[DATA_W]) begin
                        ent_d[i].rdy[k] = 1'b1;
                        ent_d[i].val[k] = snp[DATA_W-1:0];
                    end
                end
                if (w_grant[i]) ent_d[i].valid = 1'b0;
            end
            if (w_issue) begin
                out_valid_d  = 1'b1;
                out_target_d = ent_q[w_sel_idx].target;
                out_result_d = w_alu_result;
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_accept && w_free[i]) begin
                    ent_d[i].valid  = 1'b1;
                    ent_d[i].target = in_target_i;
                    ent_d[i].op     = in_op_i;
                    ent_d[i].tag[0] = in_tag1_i;
                    ent_d[i].tag[1] = in_tag2_i;
                    snp = snoop(in_tag1_i, cdb_valid_i, cdb_tag_i, cdb_val_i);
                    ent_d[i].rdy[0] = in_rdy1_i || snp[DATA_W];
                    ent_d[i].val[0] = in_rdy1_i ? in_val1_i : snp[DATA_W-1:0];
                    snp = snoop(in_tag2_i, cdb_valid_i, cdb_tag_i, cdb_val_i);
                    ent_d[i].rdy[1] = in_rdy2_i || snp[DATA_W];
                    ent_d[i].val[1] = in_rdy2_i ? in_val2_i : snp[DATA_W-1:0];
                    for (int j = 0; j < ENTRIES; j++) begin
                        older_d[j][i] = age_older(w_valid[j], j, i);
                        older_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            older_q      <= '0;
            out_valid_q  <= 1'b0;
            out_target_q <= '0;
            out_result_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
            older_q      <= older_d;
            out_valid_q  <= out_valid_d;
            out_target_q <= out_target_d;
            out_result_q <= out_result_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_target_o = out_target_q;
    assign out_result_o = out_result_q;

endmodule

`default_nettype wire
